// File: rtl/cmm_add_arbiter.sv
// cmm_add_arbiter: round-robin packet arbiter in front of a shared matrix adder, with ID-tagged results
module cmm_add_arbiter #(
    parameter int MAT_WIDTH    = 4,
    parameter int MAT_HEIGHT   = 4,
    parameter int ELEMENT_SIZE = 16,
    parameter int ID_DEPTH     = 4,
    localparam int DW = MAT_WIDTH * MAT_HEIGHT * ELEMENT_SIZE,
    localparam int AW = $clog2(ID_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] r0_a_tdata,
    input  logic [DW-1:0] r0_b_tdata,
    input  logic          r0_tvalid,
    input  logic          r0_tlast,
    output logic          r0_tready,
    input  logic [DW-1:0] r1_a_tdata,
    input  logic [DW-1:0] r1_b_tdata,
    input  logic          r1_tvalid,
    input  logic          r1_tlast,
    output logic          r1_tready,
    output logic [DW-1:0] add_a_tdata,
    output logic [DW-1:0] add_b_tdata,
    output logic          add_tvalid,
    output logic          add_tlast,
    input  logic          add_tready,
    input  logic [DW-1:0] res_tdata,
    input  logic          res_tvalid,
    input  logic          res_tlast,
    output logic          res_tready,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    output logic          m_axis_tid,
    input  logic          m_axis_tready,
    output logic          err_orphan
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;
    logic [1:0]  state, state_nx;
    logic        rr_ptr;
    logic        mem [ID_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic        full, empty, sel_id, accept, pop;
    assign full   = count == (AW+1)'(ID_DEPTH);
    assign empty  = count == '0;
    assign sel_id = state == GNT1;
    assign add_a_tdata = sel_id ? r1_a_tdata : r0_a_tdata;
    assign add_b_tdata = sel_id ? r1_b_tdata : r0_b_tdata;
    assign add_tlast   = sel_id ? r1_tlast : r0_tlast;
    assign add_tvalid  = ~reset & ~full & ((state == GNT0 & r0_tvalid) | (state == GNT1 & r1_tvalid));
    assign r0_tready   = ~reset & add_tready & ~full & (state == GNT0);
    assign r1_tready   = ~reset & add_tready & ~full & (state == GNT1);
    assign accept      = add_tvalid & add_tready;
    assign m_axis_tdata  = res_tdata;
    assign m_axis_tlast  = res_tlast;
    assign m_axis_tvalid = ~reset & res_tvalid & ~empty;
    assign m_axis_tid    = mem[rptr];
    assign res_tready    = ~reset & (empty | m_axis_tready);
    assign pop           = res_tvalid & res_tready & ~empty;
    // next grant: on contention rr_ptr picks the winner; a packet holds the grant until its last beat
    always_comb begin
        state_nx = state == IDLE ? (r0_tvalid & (~r1_tvalid | ~rr_ptr) ? GNT0 : r1_tvalid ? GNT1 : IDLE)
                 : (accept & add_tlast) | state == 2'd3 ? IDLE : state;
    end
    // arbitration state, round-robin pointer, ID FIFO pointers and sticky orphan flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept & add_tlast) rr_ptr <= state == GNT0;
            if (accept) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            if (res_tvalid & empty) err_orphan <= 1'b1;
        end
    end
    // ID storage needs no reset: entries are only read once counted in
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= sel_id;
    end
endmodule

// File: tb/tb_cmm_add_arbiter.sv
// tb_cmm_add_arbiter: directed checks of grant order, packet atomicity, FIFO backpressure, orphans and reset
module tb_cmm_add_arbiter;
    localparam int DW = 256;
    logic clk = 0, reset = 1;
    logic [DW-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0, add_a, add_b, res_d = '0, m_d;
    logic r0_v = 0, r0_l = 0, r0_r, r1_v = 0, r1_l = 0, r1_r;
    logic add_v, add_l, add_r = 1, res_v = 0, res_l = 0, res_r;
    logic m_v, m_l, m_id, m_r = 1, err;
    int total = 0, bad = 0;
    cmm_add_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_a_tdata(r0_a), .r0_b_tdata(r0_b), .r0_tvalid(r0_v), .r0_tlast(r0_l), .r0_tready(r0_r),
        .r1_a_tdata(r1_a), .r1_b_tdata(r1_b), .r1_tvalid(r1_v), .r1_tlast(r1_l), .r1_tready(r1_r),
        .add_a_tdata(add_a), .add_b_tdata(add_b), .add_tvalid(add_v), .add_tlast(add_l), .add_tready(add_r),
        .res_tdata(res_d), .res_tvalid(res_v), .res_tlast(res_l), .res_tready(res_r),
        .m_axis_tdata(m_d), .m_axis_tvalid(m_v), .m_axis_tlast(m_l), .m_axis_tid(m_id), .m_axis_tready(m_r),
        .err_orphan(err)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    initial begin
        r0_v = 1; res_v = 1;
        #1;
        chk("rst_r0_tready", r0_r, 0);
        chk("rst_add_tvalid", add_v, 0);
        chk("rst_res_tready", res_r, 0);
        chk("rst_m_tvalid", m_v, 0);
        tick; tick;
        chk("rst_err", err, 0);
        reset = 0; r0_v = 0; res_v = 0;
        #1;
        chk("rst_state", dut.state, 0);
        chk("rst_count", dut.count, 0);
        chk("rst_rr", dut.rr_ptr, 0);
        // R0 alone, 3 beats
        r0_v = 1; r0_a = 1; r0_b = 2;
        #1;
        chk("t1_idle_add_v", add_v, 0);
        chk("t1_idle_r0_r", r0_r, 0);
        tick;
        chk("t1_b1_add_v", add_v, 1);
        chk("t1_b1_add_a", add_a, 1);
        chk("t1_b1_add_b", add_b, 2);
        chk("t1_b1_r0_r", r0_r, 1);
        chk("t1_b1_r1_r", r1_r, 0);
        tick;
        r0_a = 3;
        #1;
        chk("t1_b2_add_a", add_a, 3);
        chk("t1_b2_count", dut.count, 1);
        tick;
        r0_a = 5; r0_l = 1;
        #1;
        chk("t1_b3_add_l", add_l, 1);
        tick;
        r0_v = 0; r0_l = 0;
        #1;
        chk("t1_rr", dut.rr_ptr, 1);
        chk("t1_count", dut.count, 3);
        chk("t1_state", dut.state, 0);
        for (int i = 0; i < 3; i++) begin
            res_v = 1; res_d = DW'(i + 7); res_l = i == 2;
            #1;
            chk("t1_m_v", m_v, 1);
            chk("t1_m_id", m_id, 0);
            chk("t1_m_d", m_d, DW'(i + 7));
            chk("t1_m_l", m_l, i == 2);
            tick;
        end
        res_v = 0; res_l = 0;
        #1;
        chk("t1_drained", dut.count, 0);
        // contention from reset
        reset = 1; tick; reset = 0;
        r0_v = 1; r0_a = 'h10; r1_v = 1; r1_a = 'h20; r1_l = 1;
        tick;
        chk("t2_g0_add_a", add_a, 'h10);
        chk("t2_g0_r0_r", r0_r, 1);
        chk("t2_g0_r1_r", r1_r, 0);
        tick;
        r0_l = 1;
        tick;
        chk("t2_idle_add_v", add_v, 0);
        chk("t2_rr1", dut.rr_ptr, 1);
        tick;
        chk("t2_g1_add_a", add_a, 'h20);
        chk("t2_g1_r1_r", r1_r, 1);
        chk("t2_g1_r0_r", r0_r, 0);
        tick;
        chk("t2_rr0", dut.rr_ptr, 0);
        tick;
        chk("t2_g0_again", r0_r, 1);
        chk("t2_g0_again_a", add_a, 'h10);
        tick;
        r0_v = 0; r1_v = 0; r0_l = 0; r1_l = 0;
        #1;
        chk("t2_count", dut.count, 4);
        for (int i = 0; i < 4; i++) begin
            res_v = 1;
            #1;
            chk("t2_tid", m_id, i == 2);
            tick;
        end
        res_v = 0;
        // R1 4-beat packet, R0 asserts mid-packet
        r1_v = 1;
        tick;
        tick;
        r0_v = 1;
        #1;
        chk("t3_r0_blocked", r0_r, 0);
        chk("t3_r1_r", r1_r, 1);
        tick; tick;
        r1_l = 1;
        #1;
        chk("t3_r0_blocked_last", r0_r, 0);
        tick;
        r1_v = 0; r1_l = 0; r0_v = 0;
        #1;
        chk("t3_state", dut.state, 0);
        chk("t3_rr", dut.rr_ptr, 0);
        for (int i = 0; i < 4; i++) begin
            res_v = 1;
            #1;
            chk("t3_tid", m_id, 1);
            tick;
        end
        res_v = 0;
        // FIFO fills at ID_DEPTH in-flight beats
        r0_v = 1;
        tick;
        tick; tick; tick; tick;
        chk("t4_count", dut.count, 4);
        chk("t4_add_v", add_v, 0);
        chk("t4_r0_r", r0_r, 0);
        tick;
        chk("t4_hold", dut.count, 4);
        res_v = 1;
        #1;
        chk("t4_m_v", m_v, 1);
        tick;
        res_v = 0;
        #1;
        chk("t4_count3", dut.count, 3);
        chk("t4_add_v1", add_v, 1);
        chk("t4_r0_r1", r0_r, 1);
        tick;
        chk("t4_full_again", add_v, 0);
        tick;
        chk("t4_one_more", dut.count, 4);
        res_v = 1; r0_l = 1;
        tick;
        chk("t4_pop", dut.count, 3);
        tick;
        chk("t4_pushpop", dut.count, 3);
        chk("t4_idle", dut.state, 0);
        r0_v = 0; r0_l = 0;
        tick; tick; tick;
        res_v = 0;
        #1;
        chk("t4_drained", dut.count, 0);
        chk("t4_err", err, 0);
        // orphan sum
        res_v = 1;
        #1;
        chk("t5_m_v", m_v, 0);
        chk("t5_res_r", res_r, 1);
        chk("t5_err0", err, 0);
        tick;
        res_v = 0;
        chk("t5_err1", err, 1);
        tick; tick;
        chk("t5_sticky", err, 1);
        // reset during beat 2 of 3
        r0_v = 1;
        tick;
        tick;
        chk("t6_b2_r0_r", r0_r, 1);
        reset = 1;
        #1;
        chk("t6_rst_r0_r", r0_r, 0);
        chk("t6_rst_add_v", add_v, 0);
        tick;
        reset = 0;
        #1;
        chk("t6_state", dut.state, 0);
        chk("t6_count", dut.count, 0);
        chk("t6_rr", dut.rr_ptr, 0);
        chk("t6_err", err, 0);
        chk("t6_add_v", add_v, 0);
        chk("t6_r0_r", r0_r, 0);
        r0_v = 0;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
